// File: rtl/race_timer_if.sv
// Signal bundle between the game-state controller (master) and race_timer (slave):
// race status levels in, timer overlay digits and flags out.
interface race_timer_if;
  logic        game_reset;
  logic        start_en;
  logic        pause;
  logic        crash_en;
  logic        finish_en;
  logic [15:0] time_bcd;
  logic [15:0] best_bcd;
  logic        running;
  logic        overflow;
  logic        new_best;

  modport master (
    output game_reset, start_en, pause, crash_en, finish_en,
    input  time_bcd, best_bcd, running, overflow, new_best
  );

  modport slave (
    input  game_reset, start_en, pause, crash_en, finish_en,
    output time_bcd, best_bcd, running, overflow, new_best
  );
endinterface

// File: rtl/race_timer.sv
// Race elapsed-time / best-time keeper with packed BCD outputs (ss.cc).
// Define RACE_TIMER_BEST_EN to build the best-time register and new_best pulse.
//
// state   | meaning
// IDLE    | waiting for a start edge, time held at 0000
// RUN     | prescaler counting, time advancing
// PAUSED  | prescaler and time held
// CRASHED | time frozen, best never updated
// DONE    | time frozen, best updated on entry
module race_timer #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic         clk,
  input  logic         reset,
  race_timer_if.slave  bus
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] TC = PW'(DIV - 1);

  typedef enum logic [2:0] {IDLE, RUN, PAUSED, CRASHED, DONE} state_t;

  state_t        state, next_state;
  logic          start_q, start_rise;
  logic [PW-1:0] pre;
  logic [15:0]   time_q;
  logic          ovf_q, run_q;
  logic          clear_run, advance, tick;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign start_rise = bus.start_en & ~start_q;

  always_comb begin
    next_state = state;
    clear_run  = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (start_rise) begin
          next_state = RUN;
          clear_run  = 1'b1;
        end
      end
      RUN: begin
        if (bus.finish_en)     next_state = DONE;
        else if (bus.crash_en) next_state = CRASHED;
        else if (bus.pause)    next_state = PAUSED;
        else                   advance    = 1'b1;
      end
      PAUSED: begin
        if (bus.finish_en)     next_state = DONE;
        else if (bus.crash_en) next_state = CRASHED;
        else if (!bus.pause)   next_state = RUN;
      end
      CRASHED, DONE: begin
        if (start_rise) begin
          next_state = RUN;
          clear_run  = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
    if (bus.game_reset) begin
      next_state = IDLE;
      clear_run  = 1'b1;
      advance    = 1'b0;
    end
  end

  // Only a non-exit RUN cycle advances, so a tick in an exit cycle is dropped.
  assign tick = advance && (pre == TC);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      start_q <= 1'b0;
      pre     <= '0;
      time_q  <= 16'h0000;
      ovf_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state   <= next_state;
      start_q <= bus.start_en;
      run_q   <= (next_state == RUN);
      if (clear_run) begin
        pre    <= '0;
        time_q <= 16'h0000;
        ovf_q  <= 1'b0;
      end else if (advance) begin
        if (tick) begin
          pre <= '0;
          if (time_q == 16'h9999) ovf_q  <= 1'b1;
          else                    time_q <= bcd_inc(time_q);
        end else begin
          pre <= pre + PW'(1);
        end
      end
    end
  end

  assign bus.time_bcd = time_q;
  assign bus.running  = run_q;
  assign bus.overflow = ovf_q;

`ifdef RACE_TIMER_BEST_EN
  logic [15:0] best_q;
  logic        nb_q;
  logic        enter_done;

  // Packed BCD orders the same as binary, so a plain compare suffices.
  assign enter_done = ((state == RUN) || (state == PAUSED)) && (next_state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      best_q <= 16'h9999;
      nb_q   <= 1'b0;
    end else begin
      nb_q <= 1'b0;
      if (enter_done && (time_q < best_q)) begin
        best_q <= time_q;
        nb_q   <= 1'b1;
      end
    end
  end

  assign bus.best_bcd = best_q;
  assign bus.new_best = nb_q;
`else
  assign bus.best_bcd = 16'h9999;
  assign bus.new_best = 1'b0;
`endif
endmodule

// File: tb/tb_race_timer.sv
// Directed bench for race_timer: a 10-cycle-tick instance for the race
// sequences and a 2-cycle-tick instance for saturation at 99.99.
module tb_race_timer;
`ifdef RACE_TIMER_BEST_EN
  localparam bit BEST_EN = 1'b1;
`else
  localparam bit BEST_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  race_timer_if bus ();
  race_timer_if bus2 ();

  race_timer #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  race_timer #(.CLK_HZ(200), .TICK_HZ(100)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  typedef struct {
    logic        g, s, p, c, f;
    int          n;
    logic [15:0] t;
    logic        r, o;
    logic [15:0] b;
    logic        nb;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic g, s, p, c, f, input int n, input logic [15:0] t,
                     input logic r, input logic [15:0] b, input logic nb);
    vec_t v;
    v.g = g; v.s = s; v.p = p; v.c = c; v.f = f; v.n = n;
    v.t = t; v.r = r; v.o = 1'b0; v.b = b; v.nb = nb;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string what, input int id, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", what, id, act, exp);
    end
  endtask

  task automatic check_main(input int id, input logic [15:0] t, input logic r, o,
                            input logic [15:0] b, input logic nb);
    cmp("time_bcd", id, bus.time_bcd, t);
    cmp("running",  id, {15'b0, bus.running},  {15'b0, r});
    cmp("overflow", id, {15'b0, bus.overflow}, {15'b0, o});
    cmp("best_bcd", id, bus.best_bcd, BEST_EN ? b : 16'h9999);
    cmp("new_best", id, {15'b0, bus.new_best}, {15'b0, BEST_EN & nb});
  endtask

  task automatic check_sat(input int id, input logic [15:0] t, input logic r, o);
    cmp("sat time_bcd", id, bus2.time_bcd, t);
    cmp("sat running",  id, {15'b0, bus2.running},  {15'b0, r});
    cmp("sat overflow", id, {15'b0, bus2.overflow}, {15'b0, o});
    cmp("sat best_bcd", id, bus2.best_bcd, 16'h9999);
    cmp("sat new_best", id, {15'b0, bus2.new_best}, 16'h0000);
  endtask

  initial begin
    reset = 1'b1;
    {bus.game_reset, bus.start_en, bus.pause, bus.crash_en, bus.finish_en} = '0;
    {bus2.game_reset, bus2.start_en, bus2.pause, bus2.crash_en, bus2.finish_en} = '0;

    //  g  s  p  c  f    n     time      r   best      nb
    add(0, 0, 0, 0, 0,   3, 16'h0000, 0, 16'h9999, 0);
    add(0, 1, 0, 0, 0,   1, 16'h0000, 1, 16'h9999, 0);
    add(0, 1, 0, 0, 0, 255, 16'h0025, 1, 16'h9999, 0);
    add(0, 1, 1, 0, 0, 100, 16'h0025, 0, 16'h9999, 0);
    add(0, 1, 0, 0, 0,   1, 16'h0025, 1, 16'h9999, 0);
    add(0, 1, 0, 0, 0,   4, 16'h0025, 1, 16'h9999, 0);
    add(0, 1, 0, 0, 0,   1, 16'h0026, 1, 16'h9999, 0);
    add(0, 1, 0, 0, 0, 160, 16'h0042, 1, 16'h9999, 0);
    add(0, 1, 0, 0, 1,   1, 16'h0042, 0, 16'h0042, 1);
    add(0, 1, 0, 0, 1,   1, 16'h0042, 0, 16'h0042, 0);
    add(0, 1, 0, 0, 1,   5, 16'h0042, 0, 16'h0042, 0);
    add(0, 0, 0, 0, 0,   2, 16'h0042, 0, 16'h0042, 0);
    add(0, 1, 0, 0, 0,   1, 16'h0000, 1, 16'h0042, 0);
    add(0, 1, 0, 0, 0, 500, 16'h0050, 1, 16'h0042, 0);
    add(0, 1, 0, 0, 1,   1, 16'h0050, 0, 16'h0042, 0);
    add(0, 0, 0, 0, 0,   1, 16'h0050, 0, 16'h0042, 0);
    add(0, 1, 0, 0, 0,   1, 16'h0000, 1, 16'h0042, 0);
    add(0, 1, 0, 0, 0, 309, 16'h0030, 1, 16'h0042, 0);
    add(0, 1, 0, 1, 0,   1, 16'h0030, 0, 16'h0042, 0);
    add(0, 1, 0, 1, 0,  20, 16'h0030, 0, 16'h0042, 0);
    add(0, 0, 0, 0, 0,   1, 16'h0030, 0, 16'h0042, 0);
    add(0, 1, 0, 0, 0,   1, 16'h0000, 1, 16'h0042, 0);
    add(0, 1, 0, 0, 0,  70, 16'h0007, 1, 16'h0042, 0);
    add(0, 1, 0, 1, 1,   1, 16'h0007, 0, 16'h0007, 1);
    add(1, 1, 0, 1, 1,   1, 16'h0000, 0, 16'h0007, 0);
    add(0, 1, 0, 0, 0,   1, 16'h0000, 0, 16'h0007, 0);
    add(0, 0, 0, 0, 0,   1, 16'h0000, 0, 16'h0007, 0);
    add(0, 1, 0, 0, 0,   1, 16'h0000, 1, 16'h0007, 0);
    add(0, 1, 0, 0, 0,  33, 16'h0003, 1, 16'h0007, 0);
    add(1, 1, 0, 0, 0,   1, 16'h0000, 0, 16'h0007, 0);
    add(0, 1, 0, 0, 0,   5, 16'h0000, 0, 16'h0007, 0);
    add(0, 0, 0, 0, 0,   1, 16'h0000, 0, 16'h0007, 0);
    add(0, 1, 0, 0, 0,   1, 16'h0000, 1, 16'h0007, 0);
    add(0, 1, 0, 0, 0,  15, 16'h0001, 1, 16'h0007, 0);
    add(0, 1, 1, 0, 0,   3, 16'h0001, 0, 16'h0007, 0);
    add(0, 1, 1, 0, 1,   1, 16'h0001, 0, 16'h0001, 1);
    add(0, 1, 1, 0, 1,   1, 16'h0001, 0, 16'h0001, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_main(-1, 16'h0000, 1'b0, 1'b0, 16'h9999, 1'b0);
    check_sat(-1, 16'h0000, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      @(negedge clk);
      bus.game_reset = vecs[i].g;
      bus.start_en   = vecs[i].s;
      bus.pause      = vecs[i].p;
      bus.crash_en   = vecs[i].c;
      bus.finish_en  = vecs[i].f;
      repeat (vecs[i].n) @(posedge clk);
      #1;
      check_main(i, vecs[i].t, vecs[i].r, vecs[i].o, vecs[i].b, vecs[i].nb);
    end

    // Saturation on the 2-cycle-tick instance.
    @(negedge clk);
    bus2.start_en = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_sat(100, 16'h0010, 1'b1, 1'b0);
    repeat (180) @(posedge clk);
    @(negedge clk);
    check_sat(101, 16'h0100, 1'b1, 1'b0);
    repeat (19798) @(posedge clk);
    @(negedge clk);
    check_sat(102, 16'h9999, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_sat(103, 16'h9999, 1'b1, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_sat(104, 16'h9999, 1'b1, 1'b1);
    bus2.game_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus2.game_reset = 1'b0;
    check_sat(105, 16'h0000, 1'b0, 1'b0);

    // Hard reset clears the best time on the main instance.
    reset = 1'b1;
    {bus.game_reset, bus.start_en, bus.pause, bus.crash_en, bus.finish_en} = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_main(200, 16'h0000, 1'b0, 1'b0, 16'h9999, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/race_timer.md
# race_timer

Race elapsed-time and best-time keeper for the racing game. Sits downstream of `game_state`, consuming its start/crash/finish/pause levels, and feeds `graphics` with packed BCD digits for the on-screen timer overlay. Counts centiseconds from a clock prescaler, freezes on crash or finish, and retains the best finishing time across rounds until hard reset.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency in Hz.
- `TICK_HZ`, 100, timer resolution in Hz (one LSB of `time_bcd`); `CLK_HZ/TICK_HZ` must be an integer ≥ 2.
- `clk`  in  1  system clock; the block's single clock.
- `reset`  in  1  synchronous, active-high; clears everything, including the best time.
- `game_reset`  in  1  synchronous, active-high round reset; returns to IDLE and keeps the best time.
- `start_en`  in  1  level, high while the race is in progress; a rising edge starts a run.
- `pause`  in  1  level, high while the game is paused.
- `crash_en`  in  1  level, high once the car has crashed.
- `finish_en`  in  1  level, high once the finish line is reached.
- `time_bcd`  out  16  current time `{s_tens, s_ones, cs_tens, cs_ones}`, 4-bit BCD per digit.
- `best_bcd`  out  16  best finishing time in the same format.
- `running`  out  1  high in RUN.
- `overflow`  out  1  sticky; high once `time_bcd` saturates at 99.99.
- `new_best`  out  1  one-cycle pulse when `best_bcd` is replaced.

## Operation
- **States:** IDLE, RUN, PAUSED, CRASHED, DONE.
  - Reset: IDLE, `time_bcd` = 0000, `best_bcd` = 9999, all flags 0.
- **Edge detect:** `start_rise` = `start_en` & ~`start_en_q`, where `start_en_q` is registered every cycle and cleared by `reset`.
- **IDLE**
  - `time_bcd` is held at 0000.
  - `start_rise` → RUN. Prescaler cleared, `overflow` cleared.
- **RUN:** the prescaler counts 0 .. `CLK_HZ/TICK_HZ`−1. A tick fires on the terminal count and increments `time_bcd` as a BCD ripple: each digit wraps 9→0 and carries into the next.
  - At 9999, a tick leaves the value at 9999 and sets `overflow`; the block stays in RUN.
  - Exit priority, sampled each cycle: `finish_en` → DONE, else `crash_en` → CRASHED, else `pause` → PAUSED.
  - The tick in the exit cycle is discarded, so the frozen time is the pre-exit value.
- **PAUSED**
  - Prescaler and time are held.
  - `pause` low → RUN; the prescaler resumes from its held value (no lost partial tick).
  - `finish_en`/`crash_en` are also honoured here, with the same priority.
- **DONE**
  - On entry, if the frozen time is strictly less than `best_bcd`, `best_bcd` is loaded with it and `new_best` pulses.
  - Time is held until exit.
- **CRASHED:** time is held; best is never updated.
- **Exits from DONE/CRASHED**
  - `game_reset` → IDLE.
  - `start_rise` → RUN with time, prescaler and `overflow` cleared.
- **`game_reset` from any state:** → IDLE, `time_bcd` = 0000, prescaler and `overflow` cleared. `best_bcd` is kept.
- **Priority:** `reset` > `game_reset` > state transitions.

## Timing
- All outputs are registered.
- Tick at terminal count in cycle N → `time_bcd` updated at N+1.
- Input sampled in cycle N → state and `running` change at N+1.
- `new_best` is high exactly in the cycle DONE is first entered (N+1 after `finish_en` is sampled).
- `best_bcd` is valid in that same cycle.
- Prescaler width: clog2(`CLK_HZ/TICK_HZ`).
- `new_best` and the `best_bcd` update happen only on the RUN/PAUSED → DONE transition; a finish while already in DONE causes neither.
- Inputs are synchronous to `clk`; the block does no synchronisation.

## Configuration
- `RACE_TIMER_BEST_EN`
  - **Defined:** best-time register, comparison and `new_best` are compiled in, as described above.
  - **Undefined:** `best_bcd` is tied to 16'h9999 and `new_best` to 0. No comparator or best register is built. DONE behaves otherwise identically.

## Test plan
All scenarios use `CLK_HZ`=1000, `TICK_HZ`=100, so one tick every 10 cycles.
- **Basic count:** reset, then `start_en` rises and is held 250 cycles → `time_bcd` = 0025, `running`=1.
- **Pause:** pause for 100 cycles mid-run, then resume → count frozen during the pause and continues without loss; total = active cycles/10.
- **Finish and best:** finish after 0042 → DONE, `best_bcd` = 0042, `new_best` high for 1 cycle. A second run finishing at 0050 → `best_bcd` stays 0042, no pulse.
- **Crash and simultaneous events:** crash at 0030 → `time_bcd` frozen at 0030, best unchanged. `finish_en` and `crash_en` rising in the same cycle → DONE.
- **Saturation:** run 100,000+ cycles → `time_bcd` = 9999, `overflow`=1. After `game_reset` → IDLE, 0000, `overflow`=0, best retained.
- **Resets:** `game_reset` mid-RUN → next cycle IDLE, 0000. `reset` → `best_bcd` = 9999.
